// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
// Helpers work at DIV_W_MAX bits; callers cast their DIV_W values in and out.
package clk_div_pkg;

  localparam int DIV_W_DEFAULT = 16;
  localparam int DIV_W_MAX     = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Length of the high phase of clk_sq: ceil(n/2), computed without overflow.
  function automatic logic [DIV_W_MAX-1:0] half_hi(input logic [DIV_W_MAX-1:0] n);
    logic [DIV_W_MAX:0] w_sum;
    w_sum = {1'b0, n} + {{DIV_W_MAX{1'b0}}, 1'b1};
    return w_sum[DIV_W_MAX:1];
  endfunction

  // A zero divisor is meaningless; it is stored as 1.
  function automatic logic [DIV_W_MAX-1:0] sanitize(input logic [DIV_W_MAX-1:0] n);
    logic [DIV_W_MAX-1:0] w_res;
    if (n == {DIV_W_MAX{1'b0}}) begin
      w_res = {{(DIV_W_MAX-1){1'b0}}, 1'b1};
    end else begin
      w_res = n;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/staged divisor, registered tick and clk_sq.
// Divisor changes while running are deferred to a period boundary so no runt periods appear.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             div_ld,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick,
  output logic             clk_sq,
  output logic [DIV_W-1:0] div_cur
);

  localparam logic [DIV_W-1:0] ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE     = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  chan_state_e      r_state,    w_state_nxt;
  logic [DIV_W-1:0] r_cnt,      w_cnt_nxt;
  logic [DIV_W-1:0] r_div_act,  w_act_nxt;
  logic [DIV_W-1:0] r_div_pend, w_pend_nxt;
  logic             r_pend_vld, w_pend_vld_nxt;
  logic             r_tick,     w_tick_nxt;
  logic             r_clk_sq,   w_sq_nxt;

  logic [DIV_W-1:0] w_ld_val;
  logic [DIV_W-1:0] w_pend_val_in;
  logic             w_pend_vld_in;
  logic [DIV_W-1:0] w_act_bound;
  logic             w_last;
  logic             w_hi;

  // A load arriving this cycle supersedes any staged value (last write wins).
  assign w_ld_val      = DIV_W'(sanitize(DIV_W_MAX'(div_val)));
  assign w_pend_vld_in = div_ld | r_pend_vld;
  assign w_pend_val_in = div_ld ? w_ld_val : r_div_pend;
  assign w_act_bound   = w_pend_vld_in ? w_pend_val_in : r_div_act;
  assign w_last        = (r_cnt == (r_div_act - ONE));
  assign w_hi          = (r_cnt < DIV_W'(half_hi(DIV_W_MAX'(r_div_act))));

  // Next-state and next-output logic for the channel FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_act_nxt      = r_div_act;
    w_pend_nxt     = w_pend_val_in;
    w_pend_vld_nxt = r_pend_vld;
    w_tick_nxt     = 1'b0;
    w_sq_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_act_nxt      = w_act_bound;
        w_pend_vld_nxt = 1'b0;
        if (en) begin
          // Entry edge is count edge 1 with cnt=0, so the high phase starts here.
          w_state_nxt = ST_RUN;
          w_sq_nxt    = 1'b1;
          if (w_act_bound == ONE) begin
            w_cnt_nxt  = ZERO;
            w_tick_nxt = 1'b1;
          end else begin
            w_cnt_nxt  = ONE;
            w_tick_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = ZERO;
        end
      end
      ST_RUN: begin
        if (!en) begin
          w_state_nxt    = ST_IDLE;
          w_cnt_nxt      = ZERO;
          w_act_nxt      = w_act_bound;
          w_pend_vld_nxt = 1'b0;
        end else if (sync || w_last) begin
          w_cnt_nxt      = ZERO;
          w_act_nxt      = w_act_bound;
          w_pend_vld_nxt = 1'b0;
          w_tick_nxt     = ~sync;
          w_sq_nxt       = sync | w_hi;
        end else begin
          w_cnt_nxt      = r_cnt + ONE;
          w_pend_vld_nxt = w_pend_vld_in;
          w_sq_nxt       = w_hi;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = ZERO;
      end
    endcase
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= ZERO;
      r_div_act  <= DEF_DIV;
      r_div_pend <= DEF_DIV;
      r_pend_vld <= 1'b0;
      r_tick     <= 1'b0;
      r_clk_sq   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_act  <= w_act_nxt;
      r_div_pend <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_tick     <= w_tick_nxt;
      r_clk_sq   <= w_sq_nxt;
    end
  end

  assign tick    = r_tick;
  assign clk_sq  = r_clk_sq;
  assign div_cur = r_div_act;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider: slices the buses and
// fans out clk_in, rst and sync to one clk_div_chan per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       div_ld,
  input  logic [CHANNELS*DIV_W-1:0] div_val,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       clk_sq,
  output logic [CHANNELS*DIV_W-1:0] div_cur
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .div_ld  (div_ld[g]),
      .div_val (div_val[g*DIV_W +: DIV_W]),
      .tick    (tick[g]),
      .clk_sq  (clk_sq[g]),
      .div_cur (div_cur[g*DIV_W +: DIV_W])
    );
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock divider. Successor to the fixed power-of-two counter divider.
- Each channel produces two registered outputs from `clk_in`:
  - a one-cycle `tick` (clock enable) every N cycles;
  - a near-50% square wave `clk_sq` of period N.
- N is any integer from 1 to 2^DIV_W-1, settable per channel at runtime.
- Sits between the board clock and the pixel/CA-update logic. Consumers run on `clk_in` and use `tick` as an enable. `clk_sq` is for pins and debug only.

Parameters:
- CHANNELS, 2, number of independent divider channels.
- DIV_W, 16, divisor width in bits.
- DEFAULT_DIV, 4, divisor loaded into every channel at reset (1..2^DIV_W-1).

Ports:
- clk_in  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  CHANNELS  per-channel run enable.
- sync  in  1  synchronous phase-align pulse for all channels.
- div_ld  in  CHANNELS  per-channel divisor load strobe.
- div_val  in  CHANNELS*DIV_W  divisor values; channel i uses bits [i*DIV_W +: DIV_W].
- tick  out  CHANNELS  one-cycle pulse every N cycles.
- clk_sq  out  CHANNELS  square wave of period N.
- div_cur  out  CHANNELS*DIV_W  divisor currently in effect, per channel.

Behaviour:
- Interface: one clock (`clk_in`). Reset `rst` is asynchronous and active-high.
- Reset: per channel, cnt=0, div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV, pend_vld=0, tick=0, clk_sq=0, div_cur=DEFAULT_DIV. Reset asserted mid-period aborts immediately; no partial pulse.
- Per-channel state:
  - cnt [DIV_W-1:0]
  - div_act (divisor in effect)
  - div_pend + pend_vld (staged load)
  - tick and clk_sq registers
- Divisor 0 is illegal and is treated as 1 at load time; the stored value becomes 1.
- States per channel:
  - IDLE (en=0): cnt held at 0, tick=0, clk_sq=0.
  - RUN (en=1).
  - IDLE->RUN on the first edge sampling en=1. RUN->IDLE on the first edge sampling en=0; cnt, tick and clk_sq clear at that edge.
- RUN counting:
  - At each edge: cnt <= (cnt==div_act-1) ? 0 : cnt+1.
  - tick <= (cnt==div_act-1).
  - clk_sq <= (cnt < (div_act+1)>>1).
- Timing: the first tick goes high after the N-th edge in RUN (RUN-entry edge counts as edge 1), is 1 cycle wide, and repeats every N cycles.
- Duty cycle: clk_sq is high for ceil(N/2) cycles and low for floor(N/2).
- N=1: tick is constantly 1 and clk_sq is constantly 1 while running.
- Divisor load (glitch-free):
  - div_ld in IDLE: div_act and div_cur update at that edge.
  - div_ld in RUN: value staged in div_pend and pend_vld=1. It is applied at the next wrap edge (cnt==div_act-1), where cnt goes to 0 and pend_vld clears.
  - No runt or stretched period ever appears on tick or clk_sq.
- Simultaneous events:
  - div_ld on the wrap edge: the value loaded that cycle takes effect at that same wrap.
  - Second div_ld before the wrap: overwrites div_pend (last write wins).
- sync=1 at an edge: all RUN channels take cnt <= 0 and tick <= 0. clk_sq <= 1, or stays 0 if div_act>>1... no: clk_sq <= 1, since cnt=0 is in the high phase.
  - sync forces a wrap boundary, so any pending divisor is applied at that edge.
  - sync beats an ordinary wrap on the same edge. IDLE channels ignore sync.
- Arithmetic: all compares are unsigned DIV_W-bit. cnt never exceeds div_act-1.
- Latency: div_ld -> div_cur visible is 1 cycle in IDLE; in RUN it is at the wrap.

Decomposition:
- Package clk_div_pkg holds:
  - DIV_W_DEFAULT;
  - a function half_hi(n) = (n+1)>>1;
  - a function sanitize(n) mapping 0 to 1.
- Sub-module clk_div_chan (one channel: cnt, div_act, div_pend, outputs). It is instantiated CHANNELS times in a generate loop. The top level only slices buses and fans out sync/rst.

Test Plan:
- Reset with DEFAULT_DIV=4, then en[0]=1 -> tick[0] high on edges 4, 8, 12; clk_sq[0] pattern 1,1,0,0 repeating; div_cur[0]=4.
- Odd divisor: div_ld N=5 while IDLE, then enable -> tick every 5 cycles; clk_sq high 3 cycles, low 2.
- Load N=3 in RUN when cnt=1 of N=6 -> current 6-cycle period completes, next periods are 3 cycles; div_cur changes at that wrap and no tick period is shorter than 3 or longer than 6.
- Channels 0 (N=4) and 1 (N=6) running out of phase; pulse sync -> both cnt=0 on the same edge; next ticks occur 4 and 6 cycles later respectively.
- Load N=0 -> div_cur=1, tick stuck at 1; drop en -> tick and clk_sq both 0 on the next edge.
- Assert rst asynchronously mid-period (no clock edge) -> all outputs 0 and div_cur=DEFAULT_DIV immediately; release rst -> counting restarts from cnt=0.
